// File: rtl/sram_bridge_v2_pkg.sv
// Shared types and helpers for the CPU-side SRAM bridge.
// State encoding, uncached segment value and kseg strip rule.
package sram_bridge_v2_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_D_RD = 3'd2,
    ST_D_WR = 3'd3,
    ST_I_RD = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [2:0] KSEG1_SEG = 3'b101;

  // kseg0/kseg1 both alias the low 512 MB of physical space
  function automatic logic [31:0] kseg_strip(input logic [31:0] a);
    return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
  endfunction

endpackage

// File: rtl/sram_bridge_v2_if.sv
// Bundle of CPU-side and backend-side signals of the SRAM bridge.
// slave = bridge view, master = CPU core plus backend view.
interface sram_bridge_v2_if #(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);

  logic              flush;
  logic              cpu_hold;
  logic [31:0]       inst_cpu_addr;
  logic [DATA_W-1:0] inst_cpu_rdata;
  logic              inst_cpu_stall;
  logic [31:0]       data_cpu_addr;
  logic              data_cpu_ren;
  logic [STRB_W-1:0] data_cpu_wen;
  logic [DATA_W-1:0] data_cpu_wdata;
  logic [DATA_W-1:0] data_cpu_rdata;
  logic              data_cpu_stall;
  logic              inst_be_req;
  logic [31:0]       inst_be_addr;
  logic              inst_be_cached;
  logic              inst_be_ok;
  logic [DATA_W-1:0] inst_be_rdata;
  logic              data_be_req;
  logic [STRB_W-1:0] data_be_wen;
  logic [DATA_W-1:0] data_be_wdata;
  logic [31:0]       data_be_addr;
  logic              data_be_cached;
  logic              data_be_rok;
  logic              data_be_wok;
  logic [DATA_W-1:0] data_be_rdata;

  modport slave (
    input  flush, cpu_hold,
    input  inst_cpu_addr,
    output inst_cpu_rdata, inst_cpu_stall,
    input  data_cpu_addr, data_cpu_ren,
    input  data_cpu_wen, data_cpu_wdata,
    output data_cpu_rdata, data_cpu_stall,
    output inst_be_req, inst_be_addr,
    output inst_be_cached,
    input  inst_be_ok, inst_be_rdata,
    output data_be_req, data_be_wen,
    output data_be_wdata, data_be_addr,
    output data_be_cached,
    input  data_be_rok, data_be_wok,
    input  data_be_rdata
  );

  modport master (
    output flush, cpu_hold,
    output inst_cpu_addr,
    input  inst_cpu_rdata, inst_cpu_stall,
    output data_cpu_addr, data_cpu_ren,
    output data_cpu_wen, data_cpu_wdata,
    input  data_cpu_rdata, data_cpu_stall,
    input  inst_be_req, inst_be_addr,
    input  inst_be_cached,
    output inst_be_ok, inst_be_rdata,
    input  data_be_req, data_be_wen,
    input  data_be_wdata, data_be_addr,
    input  data_be_cached,
    output data_be_rok, data_be_wok,
    output data_be_rdata
  );

endinterface

// File: rtl/sram_addr_xlate.sv
// Virtual-to-physical kseg translation and cacheability flag.
// Purely combinational; one copy per CPU port.
module sram_addr_xlate
  import sram_bridge_v2_pkg::*;
#(
  parameter logic [2:0] UNCACHED_SEG = KSEG1_SEG,
  parameter bit         XLATE_EN     = 1'b1
) (
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o,
  output logic        cached_o
);

  assign paddr_o  = XLATE_EN ? kseg_strip(vaddr_i) : vaddr_i;
  assign cached_o = (vaddr_i[31:29] != UNCACHED_SEG);

endmodule

// File: rtl/sram_bridge_v2.sv
// Serialises an optional data access ahead of each fetch and
// holds results while the pipeline is held or flushed.
module sram_bridge_v2
  import sram_bridge_v2_pkg::*;
#(
  parameter int         DATA_W       = 32,
  parameter int         STRB_W       = DATA_W / 8,
  parameter logic [2:0] UNCACHED_SEG = KSEG1_SEG,
  parameter bit         XLATE_EN     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  sram_bridge_v2_if.slave bus
);

  state_e            state_q, state_d;
  logic              ireq_q, ireq_d;
  logic              dreq_q, dreq_d;
  logic              icached_q, icached_d;
  logic              dcached_q, dcached_d;
  logic              fpend_q, fpend_d;
  logic [STRB_W-1:0] dwen_q, dwen_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic [DATA_W-1:0] ibuf_q, ibuf_d;
  logic [DATA_W-1:0] dbuf_q, dbuf_d;

  logic [31:0]       iaddr_p, daddr_p;
  logic              icached_w, dcached_w;
  logic              busy;
  logic [DATA_W-1:0] ir_o, dr_o;

  sram_addr_xlate #(
    .UNCACHED_SEG(UNCACHED_SEG),
    .XLATE_EN    (XLATE_EN)
  ) u_ixl (
    .vaddr_i (bus.inst_cpu_addr),
    .paddr_o (iaddr_p),
    .cached_o(icached_w)
  );

  sram_addr_xlate #(
    .UNCACHED_SEG(UNCACHED_SEG),
    .XLATE_EN    (XLATE_EN)
  ) u_dxl (
    .vaddr_i (bus.data_cpu_addr),
    .paddr_o (daddr_p),
    .cached_o(dcached_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      ireq_q    <= 1'b0;
      dreq_q    <= 1'b0;
      icached_q <= 1'b0;
      dcached_q <= 1'b0;
      fpend_q   <= 1'b0;
      dwen_q    <= '0;
      dwdata_q  <= '0;
      ibuf_q    <= '0;
      dbuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      ireq_q    <= ireq_d;
      dreq_q    <= dreq_d;
      icached_q <= icached_d;
      dcached_q <= dcached_d;
      fpend_q   <= fpend_d;
      dwen_q    <= dwen_d;
      dwdata_q  <= dwdata_d;
      ibuf_q    <= ibuf_d;
      dbuf_q    <= dbuf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ireq_d    = 1'b0;
    dreq_d    = 1'b0;
    icached_d = icached_q;
    dcached_d = dcached_q;
    fpend_d   = fpend_q;
    dwen_d    = dwen_q;
    dwdata_d  = dwdata_q;
    ibuf_d    = ibuf_q;
    dbuf_d    = dbuf_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (!bus.flush) begin
          if (bus.data_cpu_ren) begin
            state_d   = ST_D_RD;
            dreq_d    = 1'b1;
            dcached_d = dcached_w;
          end else if (|bus.data_cpu_wen) begin
            state_d   = ST_D_WR;
            dreq_d    = 1'b1;
            dcached_d = dcached_w;
            dwen_d    = bus.data_cpu_wen;
            dwdata_d  = bus.data_cpu_wdata;
          end else begin
            state_d   = ST_I_RD;
            ireq_d    = 1'b1;
            icached_d = icached_w;
          end
        end
      end
      ST_D_RD: begin
        if (bus.data_be_rok) begin
          state_d   = ST_I_RD;
          dbuf_d    = bus.data_be_rdata;
          ireq_d    = 1'b1;
          icached_d = icached_w;
        end
      end
      ST_D_WR: begin
        if (bus.data_be_wok) begin
          state_d   = ST_I_RD;
          dwen_d    = '0;
          ireq_d    = 1'b1;
          icached_d = icached_w;
        end
      end
      ST_I_RD: begin
        if (bus.inst_be_ok) begin
          state_d = ST_DONE;
          ibuf_d  = bus.inst_be_rdata;
        end
      end
      ST_DONE: begin
        if (!bus.cpu_hold) state_d = ST_REQ;
      end
      default: state_d = ST_BOOT;
    endcase
    // a flush never aborts the backend; it only blanks the results
    if (state_q == ST_DONE && !bus.cpu_hold)
      fpend_d = 1'b0;
    else if (bus.flush && state_q inside
             {ST_D_RD, ST_D_WR, ST_I_RD, ST_DONE})
      fpend_d = 1'b1;
  end

  always_comb begin
    busy = 1'b1;
    ir_o = '0;
    dr_o = '0;
    unique case (state_q)
      ST_REQ: busy = !bus.flush;
      ST_DONE: begin
        busy = 1'b0;
        if (!(fpend_q || bus.flush)) begin
          ir_o = ibuf_q;
          dr_o = dbuf_q;
        end
      end
      default: busy = 1'b1;
    endcase
  end

  assign bus.inst_cpu_stall = busy && !rst;
  assign bus.data_cpu_stall = busy && !rst;
  assign bus.inst_cpu_rdata = ir_o;
  assign bus.data_cpu_rdata = dr_o;
  assign bus.inst_be_req    = ireq_q;
  assign bus.inst_be_addr   = iaddr_p;
  assign bus.inst_be_cached = icached_q;
  assign bus.data_be_req    = dreq_q;
  assign bus.data_be_wen    = dwen_q;
  assign bus.data_be_wdata  = dwdata_q;
  assign bus.data_be_addr   = daddr_p;
  assign bus.data_be_cached = dcached_q;

endmodule

// File: tb/tb_sram_bridge_v2.sv
// Bench for sram_bridge_v2: schedule-based transaction model,
// per-cycle compare process and literal directed checks.
module tb_sram_bridge_v2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_bridge_v2_if #(.DATA_W(32), .STRB_W(4)) bus ();
  sram_bridge_v2 dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // transaction model: every event placed on an absolute cycle
  bit          m_act = 1'b0;
  bit          m_ld, m_st, m_hasd;
  int          m_r0, m_freq, m_r, m_tdreq, m_tdok;
  int          m_tireq, m_tiok, m_tdone, m_texit;
  int          m_tfmid, m_tfdone;
  logic [31:0] m_ia, m_da, m_wd, m_idat, m_ddat;
  logic [31:0] m_dbuf = 32'h0;
  logic [3:0]  m_wen;

  logic [31:0] o_iaddr, o_daddr, o_ir, o_dr, o_wdata;
  logic        o_icached, o_dcached;
  logic [3:0]  o_wen_iss, o_wen_after;
  int          o_tdreq, o_tireq, o_nostall, o_reqdone;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xl(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hA000_0000)
      return a - 32'h8000_0000;
    if (a >= 32'hA000_0000 && a < 32'hC000_0000)
      return a - 32'hA000_0000;
    return a;
  endfunction

  function automatic logic cacheable(input logic [31:0] a);
    return !(a >= 32'hA000_0000 && a < 32'hC000_0000);
  endfunction

  always @(negedge clk) begin : cmp_p
    int          c;
    logic        est, ez;
    logic [31:0] eir, edr;
    if (m_act) begin
      c   = cyc;
      est = !(c == m_freq || c >= m_tdone);
      chk("inst_stall", 32'(bus.inst_cpu_stall), 32'(est));
      chk("data_stall", 32'(bus.data_cpu_stall), 32'(est));
      chk("inst_req", 32'(bus.inst_be_req), 32'(c == m_tireq));
      chk("data_req", 32'(bus.data_be_req),
          32'(m_hasd && c == m_tdreq));
      chk("data_wen", 32'(bus.data_be_wen),
          (m_st && c >= m_tdreq && c <= m_tdok) ? 32'(m_wen) : 32'h0);
      chk("inst_addr", bus.inst_be_addr, xl(m_ia));
      chk("data_addr", bus.data_be_addr, xl(m_da));
      if (bus.inst_be_req && o_tireq < 0) o_tireq = c;
      if (bus.data_be_req && o_tdreq < 0) o_tdreq = c;
      if (c == m_tireq) begin
        chk("inst_cached", 32'(bus.inst_be_cached), 32'(cacheable(m_ia)));
        o_iaddr   = bus.inst_be_addr;
        o_icached = bus.inst_be_cached;
      end
      if (m_hasd && c == m_tdreq) begin
        chk("data_cached", 32'(bus.data_be_cached), 32'(cacheable(m_da)));
        o_daddr   = bus.data_be_addr;
        o_dcached = bus.data_be_cached;
        if (m_st) begin
          chk("data_wdata", bus.data_be_wdata, m_wd);
          o_wdata   = bus.data_be_wdata;
          o_wen_iss = bus.data_be_wen;
        end
      end
      if (m_st && c == m_tdok + 1) o_wen_after = bus.data_be_wen;
      if (c >= m_tdone) begin
        ez  = (m_tfmid >= 0) || (m_tfdone >= 0 && c >= m_tfdone);
        eir = ez ? 32'h0 : m_idat;
        edr = ez ? 32'h0 : (m_ld ? m_ddat : m_dbuf);
        chk("inst_rdata", bus.inst_cpu_rdata, eir);
        chk("data_rdata", bus.data_cpu_rdata, edr);
        o_ir = bus.inst_cpu_rdata;
        o_dr = bus.data_cpu_rdata;
        if (bus.inst_be_req || bus.data_be_req) o_reqdone++;
      end
      if (!bus.inst_cpu_stall && !bus.data_cpu_stall && c != m_freq)
        o_nostall++;
    end
  end

  // called at posedge+1 of a cycle in which the bridge sits in REQ
  task automatic run_txn(
    input bit ren, input logic [3:0] wen,
    input logic [31:0] ia, da, wd, idat, ddat,
    input int dw, iw, hold, fr, fm, fd, input bit spur);
    bit ri, rr, rw;
    m_r0   = cyc;
    m_freq = fr != 0 ? cyc : -1;
    m_r    = cyc + (fr != 0 ? 1 : 0);
    m_ld   = ren;
    m_st   = !ren && wen != 4'h0;
    m_hasd = m_ld || m_st;
    m_tdreq = m_hasd ? m_r + 1 : -1;
    m_tdok  = m_hasd ? m_tdreq + dw : -1;
    m_tireq = m_hasd ? m_tdok + 1 : m_r + 1;
    m_tiok  = m_tireq + iw;
    m_tdone = m_tiok + 1;
    m_texit = m_tdone + hold;
    m_tfmid  = fm >= 0 ? m_r + 1 + (fm % (m_tdone - m_r - 1)) : -1;
    m_tfdone = fd >= 0 ? m_tdone + (fd % (hold + 1)) : -1;
    m_ia = ia; m_da = da; m_wd = wd; m_wen = wen;
    m_idat = idat; m_ddat = ddat;
    o_tdreq = -1; o_tireq = -1; o_nostall = 0; o_reqdone = 0;
    o_iaddr = 'x; o_daddr = 'x; o_ir = 'x; o_dr = 'x; o_wdata = 'x;
    o_icached = 1'bx; o_dcached = 1'bx;
    o_wen_iss = 'x; o_wen_after = 'x;
    m_act = 1'b1;
    for (int c = m_r0; c <= m_texit; c++) begin
      ri = spur && $urandom_range(0, 2) == 0;
      rr = spur && $urandom_range(0, 2) == 0;
      rw = spur && $urandom_range(0, 2) == 0;
      bus.flush = (c == m_freq) || (c == m_tfmid) || (c == m_tfdone);
      bus.cpu_hold = (c >= m_tdone && c < m_texit);
      bus.inst_cpu_addr  = ia;
      bus.data_cpu_addr  = da;
      bus.data_cpu_ren   = ren;
      bus.data_cpu_wen   = wen;
      bus.data_cpu_wdata = wd;
      bus.inst_be_ok = (c == m_tiok) ||
                       (ri && (c < m_tireq || c > m_tiok));
      bus.inst_be_rdata = (c == m_tiok) ? idat : $urandom;
      bus.data_be_rok = (m_ld && c == m_tdok) ||
        (rr && !(m_ld && c >= m_tdreq && c <= m_tdok));
      bus.data_be_wok = (m_st && c == m_tdok) ||
        (rw && !(m_st && c >= m_tdreq && c <= m_tdok));
      bus.data_be_rdata = (m_ld && c == m_tdok) ? ddat : $urandom;
      @(posedge clk); #1;
    end
    m_act = 1'b0;
    if (m_ld) m_dbuf = ddat;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.cpu_hold = 1'b0;
    bus.inst_cpu_addr = 32'h0; bus.data_cpu_addr = 32'h0;
    bus.data_cpu_ren = 1'b0; bus.data_cpu_wen = 4'h0;
    bus.data_cpu_wdata = 32'h0;
    bus.inst_be_ok = 1'b0; bus.inst_be_rdata = 32'h0;
    bus.data_be_rok = 1'b0; bus.data_be_wok = 1'b0;
    bus.data_be_rdata = 32'h0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_istall"}, 32'(bus.inst_cpu_stall), 32'h0);
    chk({tag, "_dstall"}, 32'(bus.data_cpu_stall), 32'h0);
    chk({tag, "_ir"}, bus.inst_cpu_rdata, 32'h0);
    chk({tag, "_dr"}, bus.data_cpu_rdata, 32'h0);
    chk({tag, "_ireq"}, 32'(bus.inst_be_req), 32'h0);
    chk({tag, "_dreq"}, 32'(bus.data_be_req), 32'h0);
    chk({tag, "_wen"}, 32'(bus.data_be_wen), 32'h0);
    chk({tag, "_dcached"}, 32'(bus.data_be_cached), 32'h0);
    chk({tag, "_icached"}, 32'(bus.inst_be_cached), 32'h0);
  endtask

  initial begin
    bit          ren;
    logic [3:0]  wen;
    int          k;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("por");
    rst = 1'b0;
    @(negedge clk);
    chk("boot_stall", 32'(bus.inst_cpu_stall), 32'h1);
    @(posedge clk); #1;

    // fetch from kseg1 boot vector
    run_txn(1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h0,
            32'h3C08_BFAF, 32'h0, 0, 3, 0, 0, -1, -1, 1'b0);
    chk("t1_iaddr", o_iaddr, 32'h1FC0_0000);
    chk("t1_icached", 32'(o_icached), 32'h0);
    chk("t1_ir", o_ir, 32'h3C08_BFAF);
    chk("t1_dr", o_dr, 32'h0);
    chk("t1_done_cycles", 32'(o_nostall), 32'h1);

    // load from kseg0
    run_txn(1'b1, 4'h0, 32'h8000_0000, 32'h8000_1000, 32'h0,
            32'h2402_0001, 32'h1234_5678, 1, 1, 0, 0, -1, -1, 1'b0);
    chk("t2_daddr", o_daddr, 32'h0000_1000);
    chk("t2_dcached", 32'(o_dcached), 32'h1);
    chk("t2_dr", o_dr, 32'h1234_5678);
    chk("t2_order_gap", 32'(o_tireq - o_tdreq), 32'h2);

    // uncached store
    run_txn(1'b0, 4'b0011, 32'h8000_0004, 32'hA000_2000,
            32'hAABB_CCDD, 32'h0000_0001, 32'h0, 2, 0, 0, 0, -1, -1,
            1'b0);
    chk("t3_wen_iss", 32'(o_wen_iss), 32'h3);
    chk("t3_wen_after", 32'(o_wen_after), 32'h0);
    chk("t3_wdata", o_wdata, 32'hAABB_CCDD);
    chk("t3_dcached", 32'(o_dcached), 32'h0);
    chk("t3_fetch_gap", 32'(o_tireq - o_tdreq), 32'h3);
    chk("t3_dr_kept", o_dr, 32'h1234_5678);

    // flush while the fetch is outstanding
    run_txn(1'b0, 4'h0, 32'h0040_0000, 32'h0, 32'h0,
            32'h1111_1111, 32'h0, 0, 2, 0, 0, 1, -1, 1'b0);
    chk("t4_iaddr", o_iaddr, 32'h0040_0000);
    chk("t4_ir", o_ir, 32'h0);
    chk("t4_dr", o_dr, 32'h0);

    // four held cycles in DONE
    run_txn(1'b1, 4'h0, 32'h9FC0_1000, 32'h8000_0040, 32'h0,
            32'h0BAD_C0DE, 32'hCAFE_F00D, 0, 1, 4, 0, -1, -1, 1'b0);
    chk("t5_done_cycles", 32'(o_nostall), 32'h5);
    chk("t5_reqs_in_done", 32'(o_reqdone), 32'h0);
    chk("t5_ir", o_ir, 32'h0BAD_C0DE);
    chk("t5_dr", o_dr, 32'hCAFE_F00D);

    // reset while a load is outstanding
    idle_inputs();
    bus.data_cpu_ren = 1'b1;
    bus.data_cpu_addr = 32'h8000_0100;
    @(posedge clk); #1;
    chk("t6_dreq_pre", 32'(bus.data_be_req), 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outs("t6");
    bus.data_be_rok = 1'b1;
    bus.data_be_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.data_cpu_ren = 1'b0;
    @(negedge clk);
    chk("t6_boot_stall", 32'(bus.data_cpu_stall), 32'h1);
    @(posedge clk); #1;
    bus.data_be_rok = 1'b0;
    m_dbuf = 32'h0;
    run_txn(1'b0, 4'h0, 32'h8000_0200, 32'h0, 32'h0,
            32'h2000_0000, 32'h0, 0, 0, 0, 0, -1, -1, 1'b0);
    chk("t6_dr_ignored", o_dr, 32'h0);
    chk("t6_ir", o_ir, 32'h2000_0000);

    for (int i = 0; i < 150; i++) begin
      k   = int'($urandom_range(0, 3));
      ren = (k == 1 || k == 3);
      wen = (k >= 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(ren, wen, $urandom, $urandom, $urandom,
              $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0) ? 1 : 0,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1,
              1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
